// File: rtl/alu_host_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_host_ctrl_if
//  Description : Bundles the three channels around alu_host_ctrl.
//                  - Upstream byte stream : in_data / in_valid / in_ready
//                  - ALU issue/response   : alu_a, alu_b, alu_op, alu_start,
//                                           alu_result, alu_flags, alu_done
//                  - Downstream bytes     : out_data / out_valid / out_ready
//                  - Status               : busy
//                The master modport is the controller's view and the slave
//                modport is the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_host_ctrl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_start;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       alu_done;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic       busy;

    modport master (
        input  in_data, in_valid, alu_result, alu_flags, alu_done, out_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_start, out_data, out_valid,
               busy
    );

    modport slave (
        output in_data, in_valid, alu_result, alu_flags, alu_done, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_start, out_data, out_valid,
               busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_host_ctrl
//  Description : Byte-serial host front end for an external ALU. Accepts an
//                opcode byte (bit 7 = unary), one or two operand bytes,
//                issues a single-cycle alu_start, waits for alu_done with a
//                timeout, then returns a result byte and a flags byte.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                ena    - block enable; 0 freezes all state
//                bus    - alu_host_ctrl_if.master (upstream, ALU, downstream,
//                         busy)
//  Parameters  : TIMEOUT_CYCLES - enabled WAIT cycles before giving up
//                                 (1..255)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ena,
    alu_host_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_A    = 3'd1,
        S_GET_B    = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT     = 3'd4,
        S_SEND_RES = 3'd5,
        S_SEND_FLG = 3'd6
    } state_t;

    // Last counter value at which the ALU is still given a chance; on that
    // cycle a missing alu_done becomes a timeout.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [3:0] r_alu_op;
    logic       r_unary;
    logic [7:0] r_res;
    logic [7:0] r_flg;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_in_xfer;
    logic       w_out_xfer;
    logic       w_alu_start;
    logic       w_timeout;

    // Opcode bits 6:4 carry no meaning for this block.
    logic       w_unused_bits;
    assign w_unused_bits = ^bus.in_data[6:4];

    assign w_in_ready  = ena && (r_state == S_IDLE || r_state == S_GET_A ||
                                 r_state == S_GET_B);
    assign w_out_valid = ena && (r_state == S_SEND_RES || r_state == S_SEND_FLG);
    assign w_in_xfer   = w_in_ready  && bus.in_valid;
    assign w_out_xfer  = w_out_valid && bus.out_ready;
    assign w_timeout   = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_alu_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_xfer) w_state_nxt = S_GET_A;
            end
            S_GET_A: begin
                if (w_in_xfer) w_state_nxt = r_unary ? S_ISSUE : S_GET_B;
            end
            S_GET_B: begin
                if (w_in_xfer) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // Gated by ena so a frozen ISSUE cycle still pulses once
                // when the block is re-enabled.
                w_alu_start = ena;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done || w_timeout) w_state_nxt = S_SEND_RES;
            end
            S_SEND_RES: begin
                if (w_out_xfer) w_state_nxt = S_SEND_FLG;
            end
            S_SEND_FLG: begin
                if (w_out_xfer) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command, counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= 8'h00;
            r_alu_a  <= 8'h00;
            r_alu_b  <= 8'h00;
            r_alu_op <= 4'h0;
            r_unary  <= 1'b0;
            r_res    <= 8'h00;
            r_flg    <= 8'h00;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_alu_op <= bus.in_data[3:0];
                        r_unary  <= bus.in_data[7];
                    end
                end
                S_GET_A: begin
                    if (w_in_xfer) begin
                        r_alu_a <= bus.in_data;
                        if (r_unary) r_alu_b <= 8'h00;
                    end
                end
                S_GET_B: begin
                    if (w_in_xfer) r_alu_b <= bus.in_data;
                end
                S_ISSUE: begin
                    r_cnt <= 8'h00;
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still wins.
                    if (bus.alu_done) begin
                        r_res <= bus.alu_result;
                        r_flg <= {4'h0, bus.alu_flags};
                    end else if (w_timeout) begin
                        r_res <= 8'hFF;
                        r_flg <= 8'h80;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.alu_start = w_alu_start;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    // res is presented outside SEND_FLG so out_data reads 0x00 after reset.
    assign bus.out_data  = (r_state == S_SEND_FLG) ? r_flg : r_res;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_host_ctrl
//  Description : Self-checking bench for alu_host_ctrl. Directed commands
//                push expected ALU issues and output bytes into queues; a
//                monitor pops and compares whenever the DUT presents them.
//                A small ALU model answers alu_start after a set delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_host_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    always #5 clk = ~clk;

    alu_host_ctrl_if bus ();

    alu_host_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_out[$];
    logic [19:0] exp_iss[$];

    // ALU model control
    int         alu_delay  = 3;
    logic [7:0] alu_res    = 8'h00;
    logic [3:0] alu_flg    = 4'h0;
    bit         alu_silent = 1'b0;
    int         to_lat     = 16;

    int   last_acc   = 0;
    int   start_cyc  = 0;
    int   done_cyc   = 0;
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // ALU model: answers each alu_start alu_delay cycles later
    // ------------------------------------------------------------------
    initial begin
        bus.alu_done   = 1'b0;
        bus.alu_result = 8'h00;
        bus.alu_flags  = 4'h0;
        forever begin
            @(negedge clk);
            if (bus.alu_start && !alu_silent) begin
                repeat (alu_delay) @(posedge clk);
                #1;
                bus.alu_done   = 1'b1;
                bus.alu_result = alu_res;
                bus.alu_flags  = alu_flg;
                done_cyc       = cyc;
                @(posedge clk);
                #1;
                bus.alu_done   = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                start_cyc = cyc;
                check("start_latency", 32'(cyc - last_acc), 32'd1);
                check("start_single_pulse", {31'd0, prev_start}, 32'd0);
                if (exp_iss.size() == 0) begin
                    fail_evt("unexpected_alu_start");
                end else begin
                    check("issue_op_a_b", {12'd0, bus.alu_op, bus.alu_a, bus.alu_b},
                          {12'd0, exp_iss.pop_front()});
                end
            end
            if (bus.out_valid && !prev_valid) begin
                if (alu_silent)
                    check("timeout_latency", 32'(cyc - start_cyc), 32'(to_lat));
                else
                    check("result_latency", 32'(cyc - done_cyc), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0) begin
                    fail_evt("unexpected_out_byte");
                end else begin
                    check("out_byte", {24'd0, bus.out_data}, {24'd0, exp_out.pop_front()});
                end
            end
            prev_start = bus.alu_start;
            prev_valid = bus.out_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                last_acc = cyc;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) fail_evt("in_byte_not_accepted");
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt("wait_idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.alu_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt("wait_start_timeout");
    endtask

    // Freeze the block for 3 cycles starting two cycles after alu_start.
    task automatic freeze_in_wait();
        @(posedge clk); #1;
        @(posedge clk); #1;
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("frozen_wait_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("frozen_wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("frozen_wait_busy", {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clk); #1;
        ena = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n         = 1'b0;
        ena           = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset: in_ready follows ena
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready_ena0", {31'd0, bus.in_ready}, 32'd0);
        ena = 1'b1;
        #1;
        check("rst_in_ready_ena1", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
        check("rst_operands", {12'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
        @(posedge clk); #1;

        // Binary op
        alu_delay = 3; alu_res = 8'h3F; alu_flg = 4'h0;
        exp_iss.push_back({4'h2, 8'h35, 8'h0A});
        exp_out.push_back(8'h3F); exp_out.push_back(8'h00);
        send_byte(8'h02); send_byte(8'h35); send_byte(8'h0A);
        wait_idle();

        // Unary op
        alu_res = 8'h0F; alu_flg = 4'hA;
        exp_iss.push_back({4'h5, 8'hF0, 8'h00});
        exp_out.push_back(8'h0F); exp_out.push_back(8'h0A);
        send_byte(8'h85); send_byte(8'hF0);
        wait_idle();

        // Timeout
        alu_silent = 1'b1; to_lat = 16;
        exp_iss.push_back({4'h7, 8'h11, 8'h22});
        exp_out.push_back(8'hFF); exp_out.push_back(8'h80);
        send_byte(8'h07); send_byte(8'h11); send_byte(8'h22);
        wait_idle();
        check("timeout_busy_after", {31'd0, bus.busy}, 32'd0);
        alu_silent = 1'b0;

        // Backpressure
        bus.out_ready = 1'b0;
        alu_res = 8'h30; alu_flg = 4'h3;
        exp_iss.push_back({4'h1, 8'h10, 8'h20});
        exp_out.push_back(8'h30); exp_out.push_back(8'h03);
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h20);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_evt("bp_out_valid_timeout");
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_data", {24'd0, bus.out_data}, 32'h30);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle();

        // ena toggle in GET_B and WAIT
        alu_delay = 8; alu_res = 8'h66; alu_flg = 4'h1;
        exp_iss.push_back({4'h3, 8'h44, 8'h22});
        exp_out.push_back(8'h66); exp_out.push_back(8'h01);
        send_byte(8'h03); send_byte(8'h44);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("frozen_getb_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("frozen_getb_busy", {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        send_byte(8'h22);
        wait_start();
        freeze_in_wait();
        wait_idle();

        // Timeout counter frozen by ena: 15 enabled WAIT cycles + 3 frozen
        alu_silent = 1'b1; to_lat = 19;
        exp_iss.push_back({4'h9, 8'h01, 8'h02});
        exp_out.push_back(8'hFF); exp_out.push_back(8'h80);
        send_byte(8'h09); send_byte(8'h01); send_byte(8'h02);
        wait_start();
        freeze_in_wait();
        wait_idle();

        // Reset mid-op in WAIT
        to_lat = 16;
        exp_iss.push_back({4'h1, 8'h11, 8'h22});
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        wait_start();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_operands", {12'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (25) @(negedge clk);
        check("midrst_no_out_pending", 32'(exp_out.size()), 32'd0);
        @(posedge clk); #1;
        alu_silent = 1'b0; alu_delay = 3; alu_res = 8'h02; alu_flg = 4'h0;
        exp_iss.push_back({4'h1, 8'h01, 8'h01});
        exp_out.push_back(8'h02); exp_out.push_back(8'h00);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
        wait_idle();

        repeat (3) @(posedge clk);
        check("end_out_queue_empty", 32'(exp_out.size()), 32'd0);
        check("end_issue_queue_empty", 32'(exp_iss.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_host_ctrl.md
ALU_HOST_CTRL -- requirements
Module: alu_host_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, max cycles waited for alu_done after alu_start (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  block enable; 0 freezes all state.
REQ-005 in_data  input  8  upstream command/operand byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 alu_a, alu_b  output  8 each  operands presented to ALU.
REQ-009 alu_op  output  4  ALU opcode.
REQ-010 alu_start  output  1  one-cycle issue pulse to ALU.
REQ-011 alu_result  input  8  ALU result byte.
REQ-012 alu_flags  input  4  ALU flags {C,Z,N,V}.
REQ-013 alu_done  input  1  result/flags valid this cycle.
REQ-014 out_data  output  8  downstream response byte.
REQ-015 out_valid  output  1  out_data valid.
REQ-016 out_ready  input  1  downstream accepts out_data.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Byte transfer in: occurs on a rising edge with in_valid=1, in_ready=1, ena=1; out: out_valid=1, out_ready=1, ena=1.
REQ-019 States: IDLE, GET_A, GET_B, ISSUE, WAIT, SEND_RES, SEND_FLG.
REQ-020 in_ready=1 only in IDLE, GET_A, GET_B with ena=1; 0 otherwise.
REQ-021 IDLE: on transfer, latch op byte (alu_op<=in_data[3:0], unary<=in_data[7]), go GET_A; in_data[6:4] ignored.
REQ-022 GET_A: on transfer, alu_a<=in_data; go GET_B if unary=0, else alu_b<=0x00 and go ISSUE.
REQ-023 GET_B: on transfer, alu_b<=in_data, go ISSUE.
REQ-024 ISSUE: alu_start=1 for exactly this one cycle, clear timeout counter, go WAIT unconditionally.
REQ-025 alu_a, alu_b, alu_op held stable from latch until FSM returns to IDLE.
REQ-026 WAIT: counter increments each enabled cycle; alu_done=1 -> capture res<=alu_result, flg<={1'b0,3'b000,alu_flags}, go SEND_RES.
REQ-027 WAIT timeout: counter reaches TIMEOUT_CYCLES without alu_done -> res<=0xFF, flg<=0x80, go SEND_RES; alu_done in the same cycle as timeout wins (normal capture).
REQ-028 alu_done outside WAIT ignored.
REQ-029 SEND_RES: out_valid=1, out_data=res; on out transfer go SEND_FLG; out_data stable while stalled.
REQ-030 SEND_FLG: out_valid=1, out_data=flg; on out transfer go IDLE.
REQ-031 Latency: alu_start asserts the cycle after last operand accepted; out_valid asserts the cycle after alu_done sampled; back-to-back command accepted the cycle after SEND_FLG completes.
REQ-032 ena=0: state, counter, registers hold; in_ready=0, out_valid=0, alu_start=0; an ISSUE cycle frozen by ena=0 emits alu_start when ena returns.
REQ-033 out_valid=0 in all states other than SEND_RES/SEND_FLG.

Reset
REQ-034 rst_n=0 at a rising edge: state IDLE, counter 0, alu_a=alu_b=0x00, alu_op=0x0, res=flg=0x00, unary=0, regardless of ena or current state.
REQ-035 During and after reset until first transfer: in_ready=ena, alu_start=0, out_valid=0, busy=0, out_data=0x00.
REQ-036 Reset mid-transaction discards partial command and pending response; no alu_start or out byte emitted afterwards for it.

Verification
REQ-037 Binary op: in bytes 0x02,0x35,0x0A; ALU responds alu_done 3 cycles after start with 0x3F, flags 0x0 -> alu_a=0x35, alu_b=0x0A, alu_op=0x2, one alu_start pulse, out bytes 0x3F then 0x00.
REQ-038 Unary op: in bytes 0x85,0xF0 -> no GET_B, alu_b=0x00, alu_op=0x5, alu_start the cycle after 0xF0 accepted; result 0x0F flags 0xA -> out 0x0F, 0x0A.
REQ-039 Timeout: TIMEOUT_CYCLES=15, alu_done never asserted -> after 15 WAIT cycles out bytes 0xFF then 0x80, busy drops after second transfer.
REQ-040 Backpressure: out_ready=0 for 5 cycles in SEND_RES -> out_data held at res, out_valid held 1, in_ready=0; then two bytes delivered in order.
REQ-041 ena toggle: ena=0 for 3 cycles in WAIT and during GET_B -> no state change, in_ready=0, counter frozen, transaction completes correctly after ena=1.
REQ-042 Reset mid-op: rst_n=0 one cycle in WAIT -> IDLE, busy=0, no output bytes; next command 0x01,0x01,0x01 processes normally.
